// File: rtl/pipeline_sched.sv
// Round-robin scheduler for two requesters feeding a three-stage encode/ALU/parity pipeline.
// A stalled output register freezes every stage and suppresses grants.
module pipeline_sched #(
  parameter bit PAR_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] fncode0,
  input  logic [3:0] srcA0,
  input  logic [3:0] srcB0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] fncode1,
  input  logic [3:0] srcA1,
  input  logic [3:0] srcB1,
  output logic       gnt1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_tag,
  output logic [3:0] out_result,
  output logic       out_parity,
  output logic       out_err,
  output logic       busy
);

  // Lowest set bit wins; an all-zero code decodes to ADD.
  function automatic logic [2:0] enc_op(input logic [7:0] f);
    logic [2:0] op;
    op = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (f[i]) op = 3'(i);
    end
    return op;
  endfunction

  function automatic logic enc_err(input logic [7:0] f);
    return (f == 8'd0) || ((f & (f - 8'd1)) != 8'd0);
  endfunction

  function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a ^ b;
      3'd3:    r = a | b;
      3'd4:    r = a & b;
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a & b);
      3'd7:    r = ~(a ^ b);
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  logic       last_q, last_d;
  logic       s1_valid_q, s1_valid_d, s1_tag_q, s1_tag_d, s1_err_q, s1_err_d;
  logic [2:0] s1_op_q, s1_op_d;
  logic [3:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic       s2_valid_q, s2_valid_d, s2_tag_q, s2_tag_d, s2_err_q, s2_err_d;
  logic [3:0] s2_res_q, s2_res_d;
  logic       out_valid_q, out_valid_d, out_tag_q, out_tag_d, out_err_q, out_err_d;
  logic       out_parity_q, out_parity_d;
  logic [3:0] out_result_q, out_result_d;

  logic       stall, gnt0_c, gnt1_c;
  logic [7:0] sel_fn;
  logic [3:0] sel_a, sel_b;

  always_comb begin
    stall  = out_valid_q && !out_ready;
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst && !stall) begin
      if (req0 && req1) begin
        gnt0_c = last_q;
        gnt1_c = !last_q;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
    sel_fn = gnt1_c ? fncode1 : fncode0;
    sel_a  = gnt1_c ? srcA1   : srcA0;
    sel_b  = gnt1_c ? srcB1   : srcB0;
  end

  always_comb begin
    last_d       = last_q;
    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    s1_op_d      = s1_op_q;
    s1_err_d     = s1_err_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s2_valid_d   = s2_valid_q;
    s2_tag_d     = s2_tag_q;
    s2_err_d     = s2_err_q;
    s2_res_d     = s2_res_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    out_result_d = out_result_q;
    out_parity_d = out_parity_q;

    if (gnt0_c)      last_d = 1'b0;
    else if (gnt1_c) last_d = 1'b1;

    if (!stall) begin
      s1_valid_d   = gnt0_c || gnt1_c;
      s1_tag_d     = gnt1_c;
      s1_op_d      = enc_op(sel_fn);
      s1_err_d     = enc_err(sel_fn);
      s1_a_d       = sel_a;
      s1_b_d       = sel_b;
      s2_valid_d   = s1_valid_q;
      s2_tag_d     = s1_tag_q;
      s2_err_d     = s1_err_q;
      s2_res_d     = alu(s1_op_q, s1_a_q, s1_b_q);
      out_valid_d  = s2_valid_q;
      out_tag_d    = s2_tag_q;
      out_err_d    = s2_err_q;
      out_result_d = s2_res_q;
      out_parity_d = (^s2_res_q) ^ PAR_ODD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= 1'b0;
      s1_op_q      <= 3'd0;
      s1_err_q     <= 1'b0;
      s1_a_q       <= 4'd0;
      s1_b_q       <= 4'd0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= 1'b0;
      s2_err_q     <= 1'b0;
      s2_res_q     <= 4'd0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= 4'd0;
      out_parity_q <= PAR_ODD;
    end else begin
      last_q       <= last_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_op_q      <= s1_op_d;
      s1_err_q     <= s1_err_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      s2_err_q     <= s2_err_d;
      s2_res_q     <= s2_res_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      out_result_q <= out_result_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign gnt0       = gnt0_c;
  assign gnt1       = gnt1_c;
  assign out_valid  = out_valid_q;
  assign out_tag    = out_tag_q;
  assign out_result = out_result_q;
  assign out_parity = out_parity_q;
  assign out_err    = out_err_q;
  assign busy       = s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: tb/tb_pipeline_sched.sv
// Scoreboard bench for pipeline_sched: directed vectors with hand-computed results,
// an even-parity and an odd-parity instance driven in lockstep.
module tb_pipeline_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0, req1, out_ready;
  logic [7:0] fncode0, fncode1;
  logic [3:0] srcA0, srcB0, srcA1, srcB1;

  logic       gnt0, gnt1, out_valid, out_tag, out_parity, out_err, busy;
  logic [3:0] out_result;
  logic       gnt0_o, gnt1_o, out_valid_o, out_tag_o, out_parity_o, out_err_o, busy_o;
  logic [3:0] out_result_o;

  pipeline_sched #(.PAR_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst),
    .req0(req0), .fncode0(fncode0), .srcA0(srcA0), .srcB0(srcB0), .gnt0(gnt0),
    .req1(req1), .fncode1(fncode1), .srcA1(srcA1), .srcB1(srcB1), .gnt1(gnt1),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .out_parity(out_parity), .out_err(out_err), .busy(busy)
  );

  pipeline_sched #(.PAR_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst),
    .req0(req0), .fncode0(fncode0), .srcA0(srcA0), .srcB0(srcB0), .gnt0(gnt0_o),
    .req1(req1), .fncode1(fncode1), .srcA1(srcA1), .srcB1(srcB1), .gnt1(gnt1_o),
    .out_valid(out_valid_o), .out_ready(out_ready), .out_tag(out_tag_o),
    .out_result(out_result_o), .out_parity(out_parity_o), .out_err(out_err_o),
    .busy(busy_o)
  );

  typedef struct packed {
    logic [7:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic       tag;
    logic [3:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   pops  = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [7:0] fn, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] res, input logic err);
    vec_t v;
    v.fn = fn; v.a = a; v.b = b; v.res = res; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic tag, input vec_t v);
    exp_t e;
    e.tag = tag; e.res = v.res; e.err = v.err;
    sb.push_back(e);
  endtask

  // Compared every cycle the output is valid, so a held result must match the head entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL out_unexpected: got out_valid=1 tag=%0d res=%0d, expected none",
                   out_tag, out_result);
        end else begin
          e = sb[0];
          chk("out_tag", out_tag, e.tag);
          chk("out_result", out_result, e.res);
          chk("out_err", out_err, e.err);
          chk("out_parity_even", out_parity, ^e.res);
          chk("odd_valid", out_valid_o, 1);
          chk("odd_result", out_result_o, e.res);
          chk("odd_tag", out_tag_o, e.tag);
          chk("odd_err", out_err_o, e.err);
          chk("out_parity_odd", out_parity_o, ~^e.res);
          if (out_ready) begin
            void'(sb.pop_front());
            pops++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input vec_t v);
    if (port) begin
      req1 = 1'b1; fncode1 = v.fn; srcA1 = v.a; srcB1 = v.b;
    end else begin
      req0 = 1'b1; fncode0 = v.fn; srcA0 = v.a; srcB0 = v.b;
    end
  endtask

  // Present v on a port, wait (bounded) for its grant, then optionally keep requesting.
  task automatic send(input bit port, input vec_t v, input bit keep, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    drive(port, v);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port ? gnt1 : gnt0) == 1'b1) begin
        got = 1'b1;
        acc = cyc;
        push(port, v);
      end
    end
    if (!got) begin
      n_vec++;
      n_mis++;
      $display("FAIL grant_timeout: port %0d got no grant, expected one within 20 cycles",
               port);
    end
    tick();
    if (!keep) begin
      if (port) req1 = 1'b0;
      else req0 = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  vec_t ops[8];
  vec_t p0[2];
  vec_t p1[2];

  initial begin
    int a, a2, i0, i1, p;
    rst = 1'b1; out_ready = 1'b1;
    req0 = 1'b1; fncode0 = 8'h01; srcA0 = 4'd1; srcB0 = 4'd1;
    req1 = 1'b1; fncode1 = 8'h01; srcA1 = 4'd1; srcB1 = 4'd1;

    // Reset: no grants while rst is high, output register at its reset values.
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    tick();
    @(negedge clk);
    chk("rst_gnt0_b", gnt0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_parity_even", out_parity, 0);
    chk("rst_parity_odd", out_parity_o, 1);
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    // Single op with exact latency check.
    send(0, mk(8'h01, 4'd7, 4'd5, 4'hC, 1'b0), 0, a);
    @(negedge clk); chk("lat_n1_valid", out_valid, 0);
    @(negedge clk); chk("lat_n2_valid", out_valid, 0);
    @(negedge clk); chk("lat_n3_valid", out_valid, 1);
    @(negedge clk); chk("lat_n4_busy", busy, 0);
    tick();

    // Wrapping subtract.
    send(0, mk(8'h02, 4'd2, 4'd5, 4'hD, 1'b0), 0, a);
    drain();

    // All eight ops back-to-back with A=A, B=6.
    ops[0] = mk(8'h01, 4'hA, 4'h6, 4'h0, 1'b0);
    ops[1] = mk(8'h02, 4'hA, 4'h6, 4'h4, 1'b0);
    ops[2] = mk(8'h04, 4'hA, 4'h6, 4'hC, 1'b0);
    ops[3] = mk(8'h08, 4'hA, 4'h6, 4'hE, 1'b0);
    ops[4] = mk(8'h10, 4'hA, 4'h6, 4'h2, 1'b0);
    ops[5] = mk(8'h20, 4'hA, 4'h6, 4'h1, 1'b0);
    ops[6] = mk(8'h40, 4'hA, 4'h6, 4'hD, 1'b0);
    ops[7] = mk(8'h80, 4'hA, 4'h6, 4'h3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(0, ops[i], i < 7, a);
      if (i == 0) a2 = a;
      if (i == 7) chk("stream_1_per_cycle", a - a2, 7);
    end
    drain();

    // Contention from reset: requester 0 wins first, then strict alternation.
    do_reset();
    p0[0] = mk(8'h01, 4'd1, 4'd2, 4'd3, 1'b0);
    p0[1] = mk(8'h01, 4'd3, 4'd3, 4'd6, 1'b0);
    p1[0] = mk(8'h04, 4'hF, 4'h5, 4'hA, 1'b0);
    p1[1] = mk(8'h08, 4'h8, 4'h1, 4'h9, 1'b0);
    i0 = 0; i1 = 0;
    drive(0, p0[0]);
    drive(1, p1[0]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_gnt0", gnt0, (k % 2) == 0);
      chk("cont_gnt1", gnt1, (k % 2) == 1);
      chk("cont_gnt0_odd", gnt0_o, (k % 2) == 0);
      chk("cont_gnt1_odd", gnt1_o, (k % 2) == 1);
      tick();
      if ((k % 2) == 0) begin
        push(0, p0[i0]);
        i0++;
        if (i0 < 2) drive(0, p0[i0]);
        else req0 = 1'b0;
      end else begin
        push(1, p1[i1]);
        i1++;
        if (i1 < 2) drive(1, p1[i1]);
        else req1 = 1'b0;
      end
    end
    drain();

    // Backpressure: 2-cycle stall when the first of three results appears.
    p = pops;
    send(0, mk(8'h01, 4'd1, 4'd1, 4'd2, 1'b0), 1, a);
    send(0, mk(8'h10, 4'hC, 4'h5, 4'h4, 1'b0), 1, a);
    send(0, mk(8'h20, 4'h3, 4'h4, 4'h8, 1'b0), 0, a);
    out_ready = 1'b0;
    drive(1, mk(8'h80, 4'h5, 4'h5, 4'hF, 1'b0));
    @(negedge clk);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_stall_gnt0", gnt0, 0);
    chk("bp_stall_gnt1", gnt1, 0);
    tick();
    @(negedge clk);
    chk("bp_stall2_gnt1", gnt1, 0);
    chk("bp_stall2_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_gnt1", gnt1, 1);
    push(1, mk(8'h80, 4'h5, 4'h5, 4'hF, 1'b0));
    tick();
    req1 = 1'b0;
    @(negedge clk);
    tick();
    chk("bp_pops_before_last", pops - p, 2);
    @(negedge clk);
    tick();
    chk("bp_pops_last", pops - p, 3);
    drain();

    // Malformed function codes.
    send(0, mk(8'h00, 4'd3, 4'd4, 4'd7, 1'b1), 0, a);
    send(1, mk(8'h14, 4'd3, 4'd5, 4'd6, 1'b1), 0, a);
    drain();

    // Reset mid-flight: two ops from requester 0 are discarded.
    send(0, mk(8'h01, 4'd2, 4'd2, 4'd4, 1'b0), 1, a);
    send(0, mk(8'h01, 4'd3, 4'd3, 4'd6, 1'b0), 0, a);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_busy_odd", busy_o, 0);
    end
    tick();
    drive(0, mk(8'h04, 4'h9, 4'h3, 4'hA, 1'b0));
    drive(1, mk(8'h08, 4'h1, 4'h2, 4'h3, 1'b0));
    @(negedge clk);
    chk("mrst_first_gnt0", gnt0, 1);
    chk("mrst_first_gnt1", gnt1, 0);
    push(0, mk(8'h04, 4'h9, 4'h3, 4'hA, 1'b0));
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("mrst_second_gnt1", gnt1, 1);
    push(1, mk(8'h08, 4'h1, 4'h2, 4'h3, 1'b0));
    tick();
    req1 = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_sched.md
# pipeline_sched

Round-robin scheduler and sequencer for the shared encode/ALU/parity pipeline. Two requesters each present an 8-bit one-hot function code and two 4-bit operands. The block grants one request per cycle, carries it through the IF/EX and EX/PAR pipeline registers with valid bits and a requester tag, and presents the registered result with backpressure. It sits between the lab's operand sources and the result consumer and is the only path into the pipeline datapath.

## Interface
- PAR_ODD, 0: parity sense; 0 → out_parity = XOR of result bits (even), 1 → inverted (odd).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has a valid operation.
- fncode0  input  8  requester 0 one-hot function code.
- srcA0, srcB0  input  4 each  requester 0 operands.
- gnt0  output  1  requester 0 accepted this cycle; a transfer occurs when req0 && gnt0.
- req1, fncode1, srcA1, srcB1, gnt1: identical set for requester 1.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_tag  output  1  requester index of the result.
- out_result  output  4  ALU result.
- out_parity  output  1  parity of out_result per PAR_ODD.
- out_err  output  1  fncode was zero or had more than one bit set.
- busy  output  1  any stage valid: IF/EX, EX/PAR or output.

## Operation
- Encode: opcode = index of the lowest set bit of fncode. If fncode is 0, opcode = 0. err = (fncode == 0) or (more than one bit set).
- ALU ops, with 4-bit wrap and no carry out:
  - 0 ADD A+B
  - 1 SUB A−B (two's complement)
  - 2 XOR
  - 3 OR
  - 4 AND
  - 5 NOR
  - 6 NAND
  - 7 XNOR
- Pipeline stages:
  - S1 IF/EX register {valid, tag, opcode[2:0], err, A, B}.
  - S2 EX/PAR register {valid, tag, err, result[3:0]}; the ALU is evaluated from S1.
  - S3 output register {out_valid, out_tag, out_err, out_result, out_parity}; parity is computed from S2.
- stall = out_valid && !out_ready. While stalled:
  - all three stages hold;
  - gnt0 = gnt1 = 0.
- When not stalled, every stage advances each cycle. An empty slot moves forward as a bubble (valid = 0).
- Arbitration is combinational from req0/req1, stall and the last pointer (last = the index granted most recently):
  - only one requester requesting → grant it;
  - both requesting → grant !last;
  - at most one grant per cycle;
  - a grant is never asserted without the matching req.
- last updates only on an accepted transfer.
- Requesters hold their request and operands until granted. The block samples operands only in the grant cycle.

## Timing
- Reset (synchronous):
  - all stage valids = 0; out_valid = 0, out_tag = 0, out_result = 0, out_err = 0;
  - out_parity = PAR_ODD (parity of zero);
  - last = 1, so requester 0 wins the first contention;
  - busy = 0; gnt0 = gnt1 = 0 during the reset cycle.
- Reset asserted mid-operation discards all in-flight operations at that edge. Nothing is emitted afterwards.
- Latency: a transfer accepted in cycle N gives out_valid = 1 in cycle N+3 with no stall.
- Throughput: 1 operation/cycle sustained while out_ready = 1.
- Results leave in acceptance order; the tag identifies the source.
- A stall of k cycles delays every in-flight result by exactly k cycles. Nothing is lost or duplicated.
- out_valid, out_tag, out_result, out_parity and out_err stay stable while out_valid && !out_ready.
- If out_ready is low in a cycle where out_valid = 0, no stall occurs and the pipeline advances into the empty output register.
- An accepted result (out_valid && out_ready) is replaced in the same edge by S2, or cleared if S2 is a bubble.

## Test plan
- Single op: req0, fncode0 = 8'h01, A = 7, B = 5 in cycle 0, out_ready = 1 → cycle 3: out_valid = 1, tag 0, result 4'hC, parity 0, err 0; busy low from cycle 4.
- Wrap and odd parity: PAR_ODD = 1, fncode = 8'h02 (SUB), A = 2, B = 5 → result 4'hD, out_parity 0. Also run each of the 8 ops once with A = 4'hA, B = 4'h6: ADD 0, SUB 4, XOR C, OR E, AND 2, NOR 1, NAND D, XNOR 3.
- Contention: req0 and req1 held high for 4 cycles from reset → grants alternate 0, 1, 0, 1; outputs in cycles 3–6 carry tags 0, 1, 0, 1 with matching results.
- Backpressure: stream 3 ops back-to-back, drop out_ready for 2 cycles when the first result appears → gnt0 = gnt1 = 0 during the stall; outputs held stable; all 3 results delivered in order; total completion delayed by exactly 2 cycles.
- Bad code: fncode = 8'h00 → opcode ADD and out_err = 1. fncode = 8'h14 → opcode 2 (XOR) and out_err = 1.
- Reset mid-flight: accept 2 ops, assert rst one cycle later → no out_valid afterwards, busy = 0, and the next contention grants requester 0 first.
